// File: rtl/i2c_slave_regfile.sv
// Byte-wide register file behind an I2C slave byte stream, with a second
// (host) port into the same storage. Bus writes carry big-endian register
// address bytes followed by data at auto-incrementing addresses; bus reads
// stream prefetched bytes from the current pointer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no segment in progress; tx prefetch from ptr runs here
// S_ADDR  | collecting the remaining register-address bytes
// S_WRITE | every accepted byte is stored at ptr, ptr post-increments
module i2c_slave_regfile #(
  parameter int ADDR_BYTES = 2,
  parameter int MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              rx_last,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              bus_active,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic              host_wr_en,
  input  logic [7:0]        host_wr_data,
  output logic [7:0]        host_rd_data,
  output logic              wr_strobe,
  output logic [MEM_AW-1:0] wr_addr,
  output logic              collision
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_AW-1:0] addr_next;
  logic [1:0]        cnt_q, cnt_d;
  logic              rx_ready_q;
  logic              bus_q;
  logic              fetch_q, fetch_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        rd_a_q;
  logic [7:0]        host_rd_q;
  logic              wr_strobe_q, wr_strobe_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic              collision_q, collision_d;
  logic [7:0]        mem_q [DEPTH];

  logic rx_acc;
  logic bus_fall;
  logic i2c_wr;
  logic host_hit_ptr;
  logic inval;
  logic consume;
  logic issue;

  // Handshake qualifiers; tx_data always mirrors mem[ptr], so a write to
  // ptr (or any rx activity) makes the prefetched byte untrustworthy.
  always_comb begin
    rx_acc       = rx_valid & rx_ready_q;
    bus_fall     = bus_q & ~bus_active;
    i2c_wr       = rx_acc & ~bus_fall & (state_q == S_WRITE) & ~rst;
    host_hit_ptr = host_wr_en & (host_addr == ptr_q);
    inval        = rx_acc | host_hit_ptr;
    consume      = tx_valid_q & tx_ready;
    issue        = ~tx_valid_q & ~fetch_q & (state_q == S_IDLE) & ~inval;
    // Shifting in MSB-first and keeping only the low bits drops the
    // address bits that lie above the storage depth.
    addr_next    = MEM_AW'({addr_q, rx_data});
  end

  // Next-state and output logic for the write FSM and the tx prefetch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    fetch_d     = issue;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    wr_strobe_d = i2c_wr;
    wr_addr_d   = i2c_wr ? ptr_q : wr_addr_q;
    collision_d = i2c_wr & host_hit_ptr;

    if (consume) begin
      ptr_d = ptr_q + MEM_AW'(1);
    end

    if (rx_acc && !bus_fall) begin
      case (state_q)
        S_IDLE, S_ADDR: begin
          if (cnt_q == 2'(ADDR_BYTES - 1)) begin
            ptr_d   = addr_next;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = rx_last ? S_IDLE : S_WRITE;
          end else if (rx_last) begin
            addr_d  = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_next;
            cnt_d   = cnt_q + 2'd1;
            state_d = S_ADDR;
          end
        end
        S_WRITE: begin
          ptr_d = ptr_q + MEM_AW'(1);
          if (rx_last) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end else if (bus_fall) begin
      addr_d  = '0;
      cnt_d   = '0;
      state_d = S_IDLE;
    end

    if (fetch_q && !inval) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rd_a_q;
    end
    if (consume || inval) begin
      tx_valid_d = 1'b0;
    end
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b0;
      bus_q       <= 1'b0;
      fetch_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      host_rd_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= 1'b1;
      bus_q       <= bus_active;
      fetch_q     <= fetch_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      host_rd_q   <= mem_q[host_addr];
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      collision_q <= collision_d;
    end
  end

  // Dual-port storage: port A = bus write / prefetch read, port B = host.
  // The bus write wins a same-address collision.
  always_ff @(posedge clk) begin
    if (i2c_wr) begin
      mem_q[ptr_q] <= rx_data;
    end
    if (host_wr_en && !(i2c_wr && host_hit_ptr)) begin
      mem_q[host_addr] <= host_wr_data;
    end
    rd_a_q <= mem_q[ptr_q];
  end

  assign rx_ready     = rx_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign host_rd_data = host_rd_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign collision    = collision_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a byte-level reference model (memory array,
// pointer, position within the current write segment) is updated at every
// clock edge by the stimulus task, and a negedge process compares outputs
// against it. Directed scenarios add literal expectations on top.
module tb_i2c_slave_regfile;

  localparam int ADDR_BYTES = 2;
  localparam int MEM_AW     = 8;
  localparam int DEPTH      = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              rx_last = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              bus_active = 1'b0;
  logic [MEM_AW-1:0] host_addr = '0;
  logic              host_wr_en = 1'b0;
  logic [7:0]        host_wr_data = '0;
  logic [7:0]        host_rd_data;
  logic              wr_strobe;
  logic [MEM_AW-1:0] wr_addr;
  logic              collision;

  i2c_slave_regfile #(.ADDR_BYTES(ADDR_BYTES), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_active(bus_active),
    .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .collision(collision)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [7:0] mem_m [DEPTH];
  bit         known [DEPTH];
  int         m_ptr = 0;
  int         pos = 0;
  int         m_addr = 0;
  logic       bus_prev = 1'b0;
  logic       exp_rdy = 1'b0;
  logic       exp_wr = 1'b0;
  int         exp_wr_addr = 0;
  logic       exp_col = 1'b0;
  logic       exp_hrd_known = 1'b0;
  logic [7:0] exp_hrd = '0;
  logic       chk_en = 1'b0;
  int         str_cnt = 0;
  int         col_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample the inputs as the DUT will see them, then advance the model.
  task automatic step();
    logic       s_rst, s_acc, s_fall, s_cons, s_last, s_hwe, s_bus, i2c_w;
    logic [7:0] s_rxd, s_hwd;
    int         s_ha, w_a;
    s_rst  = rst;
    s_acc  = rx_valid && exp_rdy;
    s_bus  = bus_active;
    s_fall = bus_prev && !bus_active;
    s_cons = tx_valid && tx_ready;
    s_last = rx_last;
    s_rxd  = rx_data;
    s_hwe  = host_wr_en;
    s_hwd  = host_wr_data;
    s_ha   = int'(host_addr);
    i2c_w  = 1'b0;
    w_a    = -1;
    @(posedge clk);
    exp_wr        = 1'b0;
    exp_col       = 1'b0;
    exp_hrd_known = s_rst ? 1'b1 : known[s_ha];
    exp_hrd       = s_rst ? 8'h00 : mem_m[s_ha];
    if (s_rst) begin
      m_ptr  = 0;
      pos    = 0;
      m_addr = 0;
    end else begin
      if (s_cons) m_ptr = (m_ptr + 1) % DEPTH;
      if (s_acc && !s_fall) begin
        if (pos < ADDR_BYTES) begin
          m_addr = (m_addr * 256) + int'(s_rxd);
          if (pos == ADDR_BYTES - 1) m_ptr = m_addr % DEPTH;
          pos++;
        end else begin
          i2c_w        = 1'b1;
          w_a          = m_ptr;
          mem_m[w_a]   = s_rxd;
          known[w_a]   = 1'b1;
          exp_wr       = 1'b1;
          exp_wr_addr  = w_a;
          m_ptr        = (m_ptr + 1) % DEPTH;
        end
        if (s_last) begin
          pos    = 0;
          m_addr = 0;
        end
      end else if (s_fall) begin
        pos    = 0;
        m_addr = 0;
      end
    end
    if (s_hwe) begin
      if (i2c_w && s_ha == w_a) exp_col = 1'b1;
      else begin
        mem_m[s_ha] = s_hwd;
        known[s_ha] = 1'b1;
      end
    end
    exp_rdy  = !s_rst;
    bus_prev = s_rst ? 1'b0 : s_bus;
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_ready", rx_ready, exp_rdy);
      chk("wr_strobe", wr_strobe, exp_wr);
      if (exp_wr) chk("wr_addr", wr_addr, exp_wr_addr);
      chk("collision", collision, exp_col);
      if (exp_hrd_known) chk("host_rd_data", host_rd_data, exp_hrd);
      if (tx_valid) begin
        if (!known[m_ptr]) begin
          tests++;
          fails++;
          $display("FAIL tx_known: got tx_valid at ptr %0h expected an initialised location", m_ptr);
        end else begin
          chk("tx_model", tx_data, mem_m[m_ptr]);
        end
      end
      if (wr_strobe) str_cnt++;
      if (collision) col_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_last  = last;
    step();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr    = a;
    host_wr_data = d;
    host_wr_en   = 1'b1;
    step();
    host_wr_en   = 1'b0;
  endtask

  task automatic host_check(input logic [7:0] a, input logic [7:0] lit, input string nm);
    host_addr = a;
    step();
    @(negedge clk);
    chk(nm, host_rd_data, lit);
  endtask

  task automatic wait_tx(input string nm);
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin
      step();
      k++;
    end
    if (!tx_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: got no tx_valid expected tx_valid within 20 cycles", nm);
    end
  endtask

  task automatic start_seg();
    bus_active = 1'b1;
    step();
  endtask

  task automatic end_seg();
    bus_active = 1'b0;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq3 [3];
    int s0;
    seq3 = '{8'h11, 8'h22, 8'h33};

    // reset state
    repeat (3) step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_collision", collision, 0);
    chk("rst_host_rd", host_rd_data, 0);
    chk("rst_rx_ready", rx_ready, 0);

    // fill storage with a known pattern a ^ 5C
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) host_write(8'(a), 8'(a) ^ 8'h5C);
    step();

    // burst write at 0x0004
    s0 = str_cnt;
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    end_seg();
    chk("burst_strobes", str_cnt - s0, 4);
    host_check(8'h04, 8'h11, "burst_m04");
    host_check(8'h07, 8'h44, "burst_m07");
    wait_tx("ptr08_tx");
    chk("ptr08_tx", tx_data, 8'h54);

    // repoint to 0x0004 and read three bytes
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b1);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tx("rd_wait");
      chk("rd_seq", tx_data, seq3[k]);
      step();
    end
    tx_ready = 1'b0;
    end_seg();

    // wrap past the top address
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    end_seg();
    host_check(8'hFE, 8'hAA, "wrap_mFE");
    host_check(8'hFF, 8'hBB, "wrap_mFF");
    host_check(8'h00, 8'hCC, "wrap_m00");
    wait_tx("wrap_ptr");
    chk("wrap_ptr_tx", tx_data, 8'h5D);

    // abort mid-address, pointer retained
    start_seg();
    send_byte(8'h00, 1'b0);
    end_seg();
    wait_tx("abort_ptr");
    chk("abort_ptr_tx", tx_data, 8'h5D);
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h5A, 1'b1);
    end_seg();
    host_check(8'h10, 8'h5A, "abort_m10");

    // same-cycle collision at 0x20
    s0 = col_cnt;
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    host_addr    = 8'h20;
    host_wr_data = 8'h99;
    host_wr_en   = 1'b1;
    send_byte(8'h77, 1'b1);
    host_wr_en   = 1'b0;
    end_seg();
    step();
    chk("coll_count", col_cnt - s0, 1);
    host_check(8'h20, 8'h77, "coll_m20");

    // stale-data guard on tx
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b1);
    end_seg();
    wait_tx("stale_first");
    chk("stale_first", tx_data, 8'h6C);
    host_write(8'h30, 8'hE1);
    chk("stale_drop", tx_valid, 0);
    wait_tx("stale_refetch");
    chk("stale_refetch", tx_data, 8'hE1);

    // host read-before-write
    host_addr    = 8'h50;
    host_wr_data = 8'h33;
    host_wr_en   = 1'b1;
    step();
    host_wr_en   = 1'b0;
    @(negedge clk);
    chk("rbw_old", host_rd_data, 8'h0C);
    host_check(8'h50, 8'h33, "rbw_new");

    // reset during a write segment commits nothing
    start_seg();
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    rst      = 1'b1;
    step();
    rx_valid   = 1'b0;
    rst        = 1'b0;
    bus_active = 1'b0;
    step();
    host_check(8'h40, 8'h1C, "rst_m40");
    wait_tx("rst_ptr");
    chk("rst_ptr_tx", tx_data, 8'hCC);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
